// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M multiply/divide unit.
// A 32-step shift-add multiplier and a restoring divider share one 64-bit
// {hi, lo} working register and work on operand magnitudes. The sign is
// applied in a single fix-up cycle at the end.
module muldiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  input  logic        md_flush,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] md_result,
  output logic        md_busy
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [2:0] OP_MUL = 3'b000;
  localparam logic [2:0] OP_REM = 3'b110;

  state_t      state_reg, state_next;
  logic [2:0]  op_reg;
  logic [31:0] a_mag_reg, b_mag_reg;
  logic        neg_reg;
  logic [31:0] hi_reg, lo_reg;
  logic [4:0]  count_reg;
  logic [31:0] result_reg;

  // Request decode, evaluated on the raw request inputs
  logic        accept;
  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        div_by_zero, div_ovf, short_cut;
  logic [31:0] short_result;

  assign accept   = md_valid & (state_reg == IDLE) & ~md_flush;
  // rs1 is signed for MUL, MULH, MULHSU, DIV, REM; rs2 for MUL, MULH, DIV, REM
  assign a_signed = md_op[2] ? ~md_op[0] : ~(md_op[1] & md_op[0]);
  assign b_signed = md_op[2] ? ~md_op[0] : ~md_op[1];
  assign a_neg    = a_signed & md_a[31];
  assign b_neg    = b_signed & md_b[31];
  assign a_mag    = a_neg ? (32'd0 - md_a) : md_a;
  assign b_mag    = b_neg ? (32'd0 - md_b) : md_b;

  assign div_by_zero  = md_op[2] & (md_b == 32'd0);
  assign div_ovf      = md_op[2] & ~md_op[0] & (md_a == 32'h8000_0000) & (md_b == 32'hFFFF_FFFF);
  assign short_cut    = div_by_zero | div_ovf;
  assign short_result = div_by_zero ? (md_op[1] ? md_a : 32'hFFFF_FFFF)
                                    : (md_op[1] ? 32'd0 : 32'h8000_0000);

  // One iteration of multiply and divide, plus the final sign fix-up
  logic [32:0] mul_sum;
  logic [32:0] div_rem_sh;
  logic        div_ok;
  logic [31:0] div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, fix_result;

  always_comb begin
    mul_sum    = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_mag_reg} : 33'd0);
    // The shifted remainder can need 33 bits for DIVU with a large divisor;
    // when it is at least the divisor the difference always fits in 32.
    div_rem_sh = {hi_reg, lo_reg[31]};
    div_ok     = (div_rem_sh >= {1'b0, b_mag_reg});
    div_diff   = div_rem_sh[31:0] - b_mag_reg;
    prod_fix   = neg_reg ? (64'd0 - {hi_reg, lo_reg}) : {hi_reg, lo_reg};
    quo_fix    = neg_reg ? (32'd0 - lo_reg) : lo_reg;
    rem_fix    = neg_reg ? (32'd0 - hi_reg) : hi_reg;
    if (op_reg[2])
      fix_result = op_reg[1] ? rem_fix : quo_fix;
    else
      fix_result = (op_reg == OP_MUL) ? prod_fix[31:0] : prod_fix[63:32];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; flush aborts from any state
  always_comb begin
    state_next = state_reg;
    if (md_flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (accept) state_next = short_cut ? DONE : CALC;
        CALC: if (count_reg == 5'd31) state_next = FIX;
        FIX:  state_next = DONE;
        DONE: if (res_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath: capture on accept, iterate in CALC, publish result in FIX
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_reg     <= 3'd0;
      a_mag_reg  <= 32'd0;
      b_mag_reg  <= 32'd0;
      neg_reg    <= 1'b0;
      hi_reg     <= 32'd0;
      lo_reg     <= 32'd0;
      count_reg  <= 5'd0;
      result_reg <= 32'd0;
    end else if (accept) begin
      op_reg    <= md_op;
      a_mag_reg <= a_mag;
      b_mag_reg <= b_mag;
      // REM follows the dividend; everything else follows sign(a)^sign(b)
      neg_reg   <= (md_op == OP_REM) ? a_neg : (a_neg ^ b_neg);
      hi_reg    <= 32'd0;
      lo_reg    <= md_op[2] ? a_mag : b_mag;
      count_reg <= 5'd0;
      if (short_cut) result_reg <= short_result;
    end else if (state_reg == CALC) begin
      if (op_reg[2]) begin
        hi_reg <= div_ok ? div_diff : div_rem_sh[31:0];
        lo_reg <= {lo_reg[30:0], div_ok};
      end else begin
        hi_reg <= mul_sum[32:1];
        lo_reg <= {mul_sum[0], lo_reg[31:1]};
      end
      count_reg <= count_reg + 5'd1;
    end else if (state_reg == FIX && !md_flush) begin
      result_reg <= fix_result;
    end
  end

  assign md_ready  = (state_reg == IDLE);
  assign md_busy   = (state_reg != IDLE);
  assign res_valid = (state_reg == DONE);
  assign md_result = result_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vector table, corner sequences (backpressure,
// flush, reset) and random operations checked against an arithmetic model.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        md_valid;
  logic        md_ready;
  logic [2:0]  md_op;
  logic [31:0] md_a, md_b;
  logic        md_flush;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] md_result;
  logic        md_busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .md_valid  (md_valid),
    .md_ready  (md_ready),
    .md_op     (md_op),
    .md_a      (md_a),
    .md_b      (md_b),
    .md_flush  (md_flush),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .md_result (md_result),
    .md_busy   (md_busy)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural reference: RV32M semantics using 64-bit integer arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub, p;
    logic [63:0] pu;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 32'd0) return 0;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 33;
  endfunction

  // Issue one op at a negedge, count edges after the accept edge until
  // res_valid is seen, optionally hold off res_ready, then check md_ready.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input int hold, input string name);
    int guard;
    int lat;
    logic ready_seen;
    guard = 0;
    while (!md_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk({name, "/ready_before"}, {31'd0, md_ready}, 32'd1);
    md_valid  = 1'b1;
    md_op     = op;
    md_a      = a;
    md_b      = b;
    res_ready = (hold == 0);
    @(posedge clk);
    #1;
    md_valid = 1'b0;
    md_op    = 3'($urandom);
    md_a     = $urandom;
    md_b     = $urandom;
    lat = 0;
    ready_seen = 1'b0;
    @(negedge clk);
    while (!res_valid && lat < 100) begin
      if (md_ready) ready_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (md_ready) ready_seen = 1'b1;
    chk({name, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "/result"}, md_result, exp);
    chk({name, "/ready_low"}, {31'd0, ready_seen}, 32'd0);
    $display("op=%0d a=%h b=%h result=%h latency=%0d", op, a, b, md_result, lat);
    for (int i = 0; i < hold; i++) begin
      md_a = $urandom;
      md_b = $urandom;
      @(negedge clk);
      chk({name, "/hold_valid"}, {31'd0, res_valid}, 32'd1);
      chk({name, "/hold_result"}, md_result, exp);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk({name, "/ready_after"}, {31'd0, md_ready}, 32'd1);
    chk({name, "/valid_after"}, {31'd0, res_valid}, 32'd0);
  endtask

  initial begin : main
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic        seen;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
    vecs[2]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vecs[3]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
    vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 0};
    vecs[9]  = '{3'd7, 32'd5,          32'd0,         32'd5,         0};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0};

    rst_n = 1'b0; md_valid = 1'b0; md_op = 3'd0; md_a = 32'd0; md_b = 32'd0;
    md_flush = 1'b0; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset/ready", {31'd0, md_ready}, 32'd1);
    chk("reset/busy", {31'd0, md_busy}, 32'd0);
    chk("reset/valid", {31'd0, res_valid}, 32'd0);
    chk("reset/result", md_result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 12; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 0, $sformatf("vec%0d", i));

    // Backpressure: result held for 5 cycles while operands wiggle
    run_op(3'd0, 32'h1234_5678, 32'h0000_0100, 32'h3456_7800, 33, 5, "backpressure");

    // Flush in CALC cycle 10, with a competing request that must be dropped
    @(negedge clk);
    md_valid = 1'b1; md_op = 3'd0; md_a = 32'd123; md_b = 32'd456;
    @(posedge clk); #1;
    md_valid = 1'b0;
    repeat (10) @(negedge clk);
    md_flush = 1'b1; md_valid = 1'b1; md_op = 3'd5; md_a = 32'd9; md_b = 32'd0;
    @(negedge clk);
    chk("flush/busy", {31'd0, md_busy}, 32'd0);
    chk("flush/ready", {31'd0, md_ready}, 32'd1);
    chk("flush/valid", {31'd0, res_valid}, 32'd0);
    @(negedge clk);
    chk("flush/no_accept", {31'd0, md_busy}, 32'd0);
    md_flush = 1'b0; md_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    chk("flush/no_result", {31'd0, seen}, 32'd0);
    run_op(3'd0, 32'd3, 32'd4, 32'd12, 33, 0, "after_flush");

    // Flush in DONE with res_ready low: result dropped, register kept
    run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 0, "pre_done_flush");
    md_valid = 1'b1; md_op = 3'd7; md_a = 32'd77; md_b = 32'd0;
    @(posedge clk); #1;
    md_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    chk("done_flush/valid_before", {31'd0, res_valid}, 32'd1);
    md_flush = 1'b1;
    @(negedge clk);
    chk("done_flush/valid", {31'd0, res_valid}, 32'd0);
    chk("done_flush/ready", {31'd0, md_ready}, 32'd1);
    chk("done_flush/result_kept", md_result, 32'd77);
    md_flush = 1'b0; res_ready = 1'b1;

    // Reset in CALC cycle 10, overriding a simultaneous request
    @(negedge clk);
    md_valid = 1'b1; md_op = 3'd3; md_a = 32'hDEAD_BEEF; md_b = 32'h1357_9BDF;
    @(posedge clk); #1;
    md_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0; md_valid = 1'b1;
    @(negedge clk);
    chk("rst_mid/busy", {31'd0, md_busy}, 32'd0);
    chk("rst_mid/ready", {31'd0, md_ready}, 32'd1);
    chk("rst_mid/valid", {31'd0, res_valid}, 32'd0);
    chk("rst_mid/result", md_result, 32'd0);
    @(negedge clk);
    chk("rst_mid/no_accept", {31'd0, md_busy}, 32'd0);
    rst_n = 1'b1; md_valid = 1'b0;
    run_op(3'd0, 32'd3, 32'd4, 32'd12, 33, 0, "after_reset");

    // Random operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      run_op(rop, ra, rb, ref_md(rop, ra, rb), ref_lat(rop, ra, rb), 0, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
